// File: rtl/multicore_pkg.sv
// Shared constants and types for the multicore pipeline.
// Holds the instruction-queue entry layout used by instr_queue and its FIFO core.
package multicore_pkg;

    localparam int INST_SIZE    = 32;
    localparam int IQ_ADDR_SIZE = 32;
    localparam int IQ_DEPTH     = 4;

    typedef struct packed {
        logic [INST_SIZE-1:0]    instruction;
        logic [IQ_ADDR_SIZE-1:0] pc;
        logic [IQ_ADDR_SIZE-1:0] pcplus4;
    } iq_entry_t;

endpackage

// File: rtl/iq_fifo_core.sv
// Pointer/count FIFO of instruction-queue entries with a synchronous clear.
// Push/pop qualification is the caller's job; clear wins over both.
module iq_fifo_core
    import multicore_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  iq_entry_t              wdata_i,
    output iq_entry_t              rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Entry storage; a cleared queue keeps stale data that is never presented as valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !clr_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop_i) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_queue.sv
// Instruction buffer between fetch and decode: in-order valid/stall handoff,
// fetch throttling with skid reserve, branch flush with in-flight response drop.
module instr_queue
    import multicore_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DEPTH     = IQ_DEPTH,
    parameter int SKID      = 2
) (
    input  logic                   i_aclk,
    input  logic                   i_areset_n,
    input  logic [INST_SIZE-1:0]   i_instruction,
    input  logic                   i_instr_valid,
    input  logic [ADDR_SIZE-1:0]   i_pc,
    input  logic [ADDR_SIZE-1:0]   i_pcplus4,
    input  logic                   i_fetch_pending,
    input  logic                   i_flush,
    output logic                   o_fetch_en,
    input  logic                   i_stall,
    output logic [INST_SIZE-1:0]   o_instruction,
    output logic [ADDR_SIZE-1:0]   o_pc,
    output logic [ADDR_SIZE-1:0]   o_pcplus4,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    iq_entry_t     wentry_s, head_s;
    logic [CW-1:0] count_s, next_count_s;
    logic          full_s, pop_s, cand_s, push_s;
    logic          drop_next_q, drop_next_d;
    logic          fetch_en_q, fetch_en_d;
    logic          overflow_q, overflow_d;

    assign wentry_s.instruction = i_instruction;
    assign wentry_s.pc          = i_pc;
    assign wentry_s.pcplus4     = i_pcplus4;

    assign full_s  = (count_s == CW'(DEPTH));
    assign o_valid = (count_s != CW'(0));
    assign pop_s   = o_valid && !i_stall && !i_flush;
    // A candidate push is a response that survives flush and wrong-path drop.
    assign cand_s  = i_instr_valid && !drop_next_q && !i_flush;
    assign push_s  = cand_s && (!full_s || pop_s);

    iq_fifo_core #(.DEPTH(DEPTH)) u_core (
        .clk_i   (i_aclk),
        .rst_ni  (i_areset_n),
        .clr_i   (i_flush),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wentry_s),
        .rdata_o (head_s),
        .count_o (count_s)
    );

    // Control next state: projected occupancy, fetch throttle, drop and sticky overflow.
    always_comb begin
        next_count_s = count_s;
        drop_next_d  = drop_next_q;
        if (i_flush) begin
            next_count_s = '0;
            drop_next_d  = i_fetch_pending;
        end else begin
            next_count_s = count_s + CW'(push_s) - CW'(pop_s);
            if (i_instr_valid && drop_next_q) begin
                drop_next_d = 1'b0;
            end else begin
                drop_next_d = drop_next_q;
            end
        end
        fetch_en_d = (next_count_s <= CW'(DEPTH - SKID)) && !i_flush;
        overflow_d = overflow_q || (cand_s && full_s && !pop_s);
    end

    // Control registers.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            drop_next_q <= 1'b0;
            fetch_en_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            drop_next_q <= drop_next_d;
            fetch_en_q  <= fetch_en_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_fetch_en    = fetch_en_q;
    assign o_overflow    = overflow_q;
    assign o_count       = count_s;
    assign o_instruction = head_s.instruction;
    assign o_pc          = head_s.pc;
    assign o_pcplus4     = head_s.pcplus4;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed vector table, reset cases,
// and randomized traffic checked against a queue-based reference model.
module tb_instr_queue;
    import multicore_pkg::*;

    localparam int DEPTH = 4;
    localparam int SKID  = 2;
    localparam int AW    = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [INST_SIZE-1:0]   instruction;
    logic                   instr_valid;
    logic [AW-1:0]          pc, pcplus4;
    logic                   fetch_pending, flush, stall;
    logic                   fetch_en;
    logic [INST_SIZE-1:0]   o_instruction;
    logic [AW-1:0]          o_pc, o_pcplus4;
    logic                   o_valid;
    logic [$clog2(DEPTH):0] o_count;
    logic                   o_overflow;

    always #5 clk = ~clk;

    instr_queue #(.ADDR_SIZE(AW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .i_aclk          (clk),
        .i_areset_n      (rst_n),
        .i_instruction   (instruction),
        .i_instr_valid   (instr_valid),
        .i_pc            (pc),
        .i_pcplus4       (pcplus4),
        .i_fetch_pending (fetch_pending),
        .i_flush         (flush),
        .o_fetch_en      (fetch_en),
        .i_stall         (stall),
        .o_instruction   (o_instruction),
        .o_pc            (o_pc),
        .o_pcplus4       (o_pcplus4),
        .o_valid         (o_valid),
        .o_count         (o_count),
        .o_overflow      (o_overflow)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue of entries plus the three flags.
    typedef struct { logic [31:0] ins; logic [31:0] pc; logic [31:0] pc4; } ent_t;
    ent_t m_q[$];
    logic m_fen, m_drop, m_ovf;

    typedef struct {
        logic v; logic [31:0] pc; logic st; logic fl; logic fp;
        logic e_valid; int e_count; logic [31:0] e_pc; logic e_fen; logic e_ovf;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fen  = 1'b0;
        m_drop = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                              input logic st, input logic fl, input logic fp);
        logic pop;
        pop = (m_q.size() != 0) && !st && !fl;
        if (fl) begin
            m_q.delete();
            m_drop = fp;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (v) begin
                if (m_drop) m_drop = 1'b0;
                else if (m_q.size() < DEPTH) m_q.push_back('{ins, p, p + 32'd4});
                else m_ovf = 1'b1;
            end
        end
        m_fen = !fl && (m_q.size() <= DEPTH - SKID);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"},    32'(o_valid),    32'(m_q.size() != 0));
        chk({tag, " count"},    32'(o_count),    32'(m_q.size()));
        chk({tag, " fetch_en"}, 32'(fetch_en),   32'(m_fen));
        chk({tag, " overflow"}, 32'(o_overflow), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk({tag, " instr"}, o_instruction, m_q[0].ins);
            chk({tag, " pc"},    o_pc,          m_q[0].pc);
            chk({tag, " pc4"},   o_pcplus4,     m_q[0].pc4);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] p, input logic st,
                        input logic fl, input logic fp, input string tag);
        logic [31:0] ins;
        ins           = $urandom;
        instr_valid   = v;
        instruction   = ins;
        pc            = p;
        pcplus4       = p + 32'd4;
        stall         = st;
        flush         = fl;
        fetch_pending = fp;
        model_step(v, ins, p, st, fl, fp);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic add(input logic v, input logic [31:0] p, input logic st, input logic fl,
                       input logic fp, input logic ev, input int ec, input logic [31:0] epc,
                       input logic efen, input logic eovf);
        vec_t t;
        t = '{v, p, st, fl, fp, ev, ec, epc, efen, eovf};
        vecs.push_back(t);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " valid"},    32'(o_valid),    32'd0);
        chk({tag, " count"},    32'(o_count),    32'd0);
        chk({tag, " fetch_en"}, 32'(fetch_en),   32'd0);
        chk({tag, " overflow"}, 32'(o_overflow), 32'd0);
        chk({tag, " instr"},    o_instruction,   32'd0);
        chk({tag, " pc"},       o_pc,            32'd0);
        chk({tag, " pc4"},      o_pcplus4,       32'd0);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instruction = '0; pc = '0; pcplus4 = '0;
        fetch_pending = 1'b0; flush = 1'b0; stall = 1'b0;
        model_reset();

        //       v  pc        st fl fp | valid cnt pc        fen ovf
        add(1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h000, 1'b1, 1'b0);
        add(1'b1, 32'h004, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h004, 1'b1, 1'b0);
        add(1'b1, 32'h008, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h008, 1'b1, 1'b0);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b0);
        add(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h100, 1'b1, 1'b0);
        add(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 2, 32'h100, 1'b1, 1'b0);
        add(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b1, 3, 32'h100, 1'b0, 1'b0);
        add(1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 4, 32'h100, 1'b0, 1'b0);
        add(1'b1, 32'h110, 1'b0, 1'b0, 1'b0, 1'b1, 4, 32'h104, 1'b0, 1'b0);
        add(1'b1, 32'h114, 1'b1, 1'b0, 1'b0, 1'b1, 4, 32'h104, 1'b0, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 3, 32'h108, 1'b0, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 2, 32'h10C, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h110, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b1);
        add(1'b1, 32'h010, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h010, 1'b1, 1'b1);
        add(1'b1, 32'h014, 1'b1, 1'b0, 1'b0, 1'b1, 2, 32'h010, 1'b1, 1'b1);
        add(1'b1, 32'h018, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h000, 1'b0, 1'b1);
        add(1'b1, 32'h01C, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b1);
        add(1'b1, 32'h040, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h040, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h000, 1'b0, 1'b1);
        add(1'b1, 32'h040, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h040, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h000, 1'b0, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b1);
        add(1'b1, 32'h050, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b1);
        add(1'b1, 32'h054, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h054, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h000, 1'b0, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h000, 1'b0, 1'b1);
        add(1'b1, 32'h060, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h060, 1'b1, 1'b1);
        add(1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h000, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_zero("in_reset");
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "post_reset");
        chk("post_reset fetch_en high", 32'(fetch_en), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].v, vecs[i].pc, vecs[i].st, vecs[i].fl, vecs[i].fp, tag);
            chk({tag, " exp_valid"},    32'(o_valid),    32'(vecs[i].e_valid));
            chk({tag, " exp_count"},    32'(o_count),    32'(vecs[i].e_count));
            chk({tag, " exp_fetch_en"}, 32'(fetch_en),   32'(vecs[i].e_fen));
            chk({tag, " exp_overflow"}, 32'(o_overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].e_valid) begin
                chk({tag, " exp_pc"},  o_pc,      vecs[i].e_pc);
                chk({tag, " exp_pc4"}, o_pcplus4, vecs[i].e_pc + 32'd4);
            end
        end

        // Reset mid-operation clears everything without waiting for a clock edge.
        step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, "pre_rst0");
        step(1'b1, 32'h204, 1'b1, 1'b0, 1'b0, "pre_rst1");
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("release fetch_en low", 32'(fetch_en), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic v, st, fl, fp;
            fl = ($urandom_range(0, 19) == 0);
            fp = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            v  = m_fen ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            step(v, $urandom & 32'hFFFF_FFFC, st, fl, fp, $sformatf("rand%0d", i));
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_zero("rand_reset");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Small instruction buffer between instr_fetch and the decode stage.
- Absorbs fetched instructions, tagged with pc and pc+4.
- Presents them in order to decode under a valid/stall handshake.
- Throttles fetch through its enable input and discards wrong-path instructions on a branch flush.

Parameters:
- ADDR_SIZE, 32, width of pc and pc+4 fields.
- DEPTH, 4, number of entries; power of two, at least 2.
- SKID, 2, entries held in reserve for fetch responses already in flight; must be less than DEPTH.

Ports:
- i_aclk  in  1  system clock.
- i_areset_n  in  1  asynchronous active-low reset.
- i_instruction  in  INST_SIZE  instruction from fetch.
- i_instr_valid  in  1  fetch output valid this cycle.
- i_pc  in  ADDR_SIZE  pc of i_instruction.
- i_pcplus4  in  ADDR_SIZE  pc+4 of i_instruction.
- i_fetch_pending  in  1  fetch has an issued cache request still outstanding (cache_req high and not yet returned).
- i_flush  in  1  branch/jump taken; discard buffered and in-flight instructions.
- o_fetch_en  out  1  drives fetch i_en.
- i_stall  in  1  decode/hazard stall; head is not consumed this cycle.
- o_instruction  out  INST_SIZE  head instruction.
- o_pc  out  ADDR_SIZE  head pc.
- o_pcplus4  out  ADDR_SIZE  head pc+4.
- o_valid  out  1  head entry valid.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky error: a push arrived while full.

Behaviour:
- Storage: register array of DEPTH entries {instruction, pc, pcplus4}. Write pointer, read pointer and count are registered.
  - Pointers wrap modulo DEPTH.
  - Count ranges 0..DEPTH.
- Reset (asynchronous): pointers 0, count 0, drop_next 0, o_overflow 0, o_fetch_en 0, all storage 0.
  - Resulting outputs: o_valid 0, o_instruction/o_pc/o_pcplus4 0, o_count 0.
  - Reset mid-operation discards all contents immediately.
- Head outputs: o_valid = (count != 0); o_instruction/o_pc/o_pcplus4 = entry at read pointer. No combinational path from any input to any output.
- Push: occurs when i_instr_valid && !drop_next && !i_flush && (count < DEPTH || pop).
  - Latency: an instruction pushed at edge N is visible at the head at N+1 if the queue was empty.
  - There is no same-cycle bypass.
- Pop: occurs when o_valid && !i_stall && !i_flush; the read pointer advances.
- Simultaneous push and pop: count unchanged. Allowed at full and at count 1.
- Overflow: i_instr_valid && !drop_next && !i_flush with count == DEPTH and no pop.
  - The data is dropped and o_overflow is set; it stays set until reset.
  - This indicates that SKID is too small.
- o_fetch_en: registered. Next value is (next_count <= DEPTH - SKID) && !i_flush.
  - It is therefore 0 in the cycle after a flush.
  - It is 1 on the first edge after reset release.
- Flush (i_flush=1) has priority over push and pop:
  - Next cycle: count 0, both pointers 0, o_valid 0.
  - Any i_instr_valid in the flush cycle is discarded.
  - drop_next <= i_fetch_pending.
- drop_next: while set, the next i_instr_valid is discarded (not pushed, no overflow) and drop_next clears on that same edge.
  - A new flush while drop_next is set reloads it from i_fetch_pending.
- Order: entries leave strictly in push order. pc/pcplus4 pass through unmodified.

Decomposition:
- INST_SIZE comes from multicore_pkg.
- Add to multicore_pkg:
  - typedef struct packed {instruction, pc, pcplus4} iq_entry_t, parameterised by ADDR_SIZE via package constants.
  - IQ_DEPTH default constant.
- One natural sub-module: iq_fifo_core (pointer/count FIFO of iq_entry_t with synchronous clear). instr_queue adds the flush/drop_next, fetch-enable and overflow logic around it.

Test Plan:
- Reset then idle: o_valid 0, o_count 0, o_fetch_en 0 during reset and 1 one cycle after release; o_overflow 0.
- Stream pc 0x0,0x4,0x8 with i_stall=0: o_valid rises 1 cycle after the first push; o_pc sequence 0x0,0x4,0x8 on consecutive cycles; o_pcplus4 is 0x4,0x8,0xC.
- i_stall=1, push 3 entries (DEPTH 4, SKID 2):
  - o_fetch_en drops after count reaches 3.
  - A 4th push is accepted, o_count 4.
  - A 5th push sets o_overflow=1 and o_count stays 4.
- At full, assert push and pop together: o_count stays 4, the head advances by one, no overflow.
- Queue holds pc 0x10,0x14. Assert i_flush with i_fetch_pending=1 and a same-cycle push of 0x18:
  - Next cycle o_valid 0, o_count 0, o_fetch_en 0.
  - The next response (pc 0x1C) is dropped.
  - The following response (pc 0x40) appears at the head.
- Flush with i_fetch_pending=0: the first response after the flush (pc 0x40) is pushed and seen at the head one cycle later.
